des_round_ctrl: RTL

// - Iterative DES round sequencer: accepts a 64-bit block, applies the FIPS 46-3 initial permutation (IP),

---
 rtl/des_round_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES round sequencer (IP, ROUNDS Feistel rounds through an external f-datapath, FP).
// Define DES_F_TIMEOUT_EN to add the WAIT timeout abort and the f_timeout_err port.
module des_round_ctrl #(
  parameter int ROUNDS    = 16,
  parameter int F_TIMEOUT = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] in_data,
  input  logic        in_decrypt,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] f_req_r,
  output logic [3:0]  f_req_key_idx,
  output logic        f_req_valid,
  input  logic [31:0] f_rsp_data,
  input  logic        f_rsp_valid,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
`ifdef DES_F_TIMEOUT_EN
  ,
  output logic        f_timeout_err
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);
  if (ROUNDS < 1 || ROUNDS > 16 || F_TIMEOUT < 1 || F_TIMEOUT > 15) begin : g_bad_param
    $error("des_round_ctrl: ROUNDS must be 1..16 and F_TIMEOUT 1..15");
  end
  state_t      state_q;
  logic [31:0] l_q, r_q;
  logic [3:0]  round_q;
  logic        mode_q;
`ifdef DES_F_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(F_TIMEOUT - 1);
  logic [3:0] wait_q;
  logic       err_q;
  assign f_timeout_err = err_q;
`endif
  // IP row r, column c takes DES bit base_r - 8c; FP is the inverse mapping.
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y[63 - 8*r - c] = x[64 - (r < 4 ? 58 + 2*r : 49 + 2*r) + 8*c];
    return y;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y[64 - (r < 4 ? 58 + 2*r : 49 + 2*r) + 8*c] = x[63 - 8*r - c];
    return y;
  endfunction
  assign in_ready      = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign f_req_valid   = state_q == REQ;
  assign out_valid     = state_q == DONE;
  assign f_req_r       = r_q;
  assign f_req_key_idx = mode_q ? LAST - round_q : round_q;
  assign out_data      = out_valid ? fp({r_q, l_q}) : '0;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
`ifdef DES_F_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef DES_F_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (in_valid) begin
          {l_q, r_q} <= ip(in_data);
          mode_q     <= in_decrypt;
          round_q    <= '0;
          state_q    <= REQ;
        end
        REQ: begin
`ifdef DES_F_TIMEOUT_EN
          wait_q  <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: if (f_rsp_valid) begin
          l_q <= r_q;
          r_q <= l_q ^ f_rsp_data;
          if (round_q == LAST) state_q <= DONE;
          else begin
            round_q <= round_q + 4'd1;
            state_q <= REQ;
          end
        end
`ifdef DES_F_TIMEOUT_EN
        else if (wait_q == TO_LAST) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else wait_q <= wait_q + 4'd1;
`endif
        DONE: if (out_ready) state_q <= IDLE;
      endcase
    end
  end
endmodule
